// File: rtl/draw_pkg.sv
// Shared types and constants for the per-frame VGA draw scheduler.
// Renderer index constants name the slices of the packed request ports.
package draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ARB   = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4
    } draw_state_t;

    localparam int         DRAW_NUM_REQ   = 4;
    localparam int         DRAW_X_W       = 8;
    localparam int         DRAW_Y_W       = 7;
    localparam logic [2:0] DRAW_BG_COLOUR = 3'b000;

    localparam int REQ_SCORE  = 0;
    localparam int REQ_ALIEN  = 1;
    localparam int REQ_PLAYER = 2;
    localparam int REQ_BULLET = 3;

endpackage

// File: rtl/vga_draw_arbiter_rr_pick.sv
// Round-robin first-one finder: returns the first set bit of pend at or
// above ptr, wrapping past the top index back to zero.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] g,
    output logic          valid
);

    logic [IW:0] idx;

    // Scan from the farthest offset down so the nearest candidate is written last.
    always_comb begin
        g     = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IW + 1)'(k);
            if (idx >= (IW + 1)'(N)) begin
                idx = idx - (IW + 1)'(N);
            end
            if (pend[idx[IW-1:0]]) begin
                g     = idx[IW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Owns the single VGA pixel-write port: clears the playfield each frame,
// then hands the port to each requesting renderer once, round-robin.
module vga_draw_arbiter
    import draw_pkg::*;
#(
    parameter int         NUM_REQ   = DRAW_NUM_REQ,
    parameter int         X_W       = DRAW_X_W,
    parameter int         Y_W       = DRAW_Y_W,
    parameter int         CLR_W     = 160,
    parameter int         CLR_H     = 120,
    parameter logic [2:0] BG_COLOUR = DRAW_BG_COLOUR,
    parameter int         TIMEOUT   = 4095
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     done,
    input  logic [NUM_REQ*X_W-1:0] x_in,
    input  logic [NUM_REQ*Y_W-1:0] y_in,
    input  logic [NUM_REQ*3-1:0]   colour_in,
    input  logic [NUM_REQ-1:0]     plot_in,
    output logic [NUM_REQ-1:0]     start,
    output logic [NUM_REQ-1:0]     grant,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic                   frame_busy,
    output logic                   timeout_err,
    output logic                   overrun_err,
    output draw_state_t            dbg_state
);

    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    // Handshake: a renderer holds req until its turn, gets a one-cycle start,
    // owns the port while grant is high, and ends ownership with one cycle of done.
    draw_state_t        state_q, state_d;
    logic [X_W-1:0]     cx_q, cx_d;
    logic [Y_W-1:0]     cy_q, cy_d;
    logic [NUM_REQ-1:0] served_q, served_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      g_q, g_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [NUM_REQ-1:0] start_q, start_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [X_W-1:0]     vga_x_q, vga_x_d;
    logic [Y_W-1:0]     vga_y_q, vga_y_d;
    logic [2:0]         vga_colour_q, vga_colour_d;
    logic               vga_plot_q, vga_plot_d;
    logic               frame_busy_q, frame_busy_d;
    logic               timeout_err_q, timeout_err_d;
    logic               overrun_err_q, overrun_err_d;

    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] g_bit;
    logic [IW-1:0]      pick_g;
    logic               pick_valid;
    logic               release_now;

    assign pend  = req & ~served_q;
    assign g_bit = NUM_REQ'(1) << g_q;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
        .pend  (pend),
        .ptr   (rr_q),
        .g     (pick_g),
        .valid (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        served_d      = served_q;
        rr_d          = rr_q;
        g_d           = g_q;
        wd_d          = wd_q;
        start_d       = '0;
        grant_d       = grant_q;
        vga_x_d       = '0;
        vga_y_d       = '0;
        vga_colour_d  = '0;
        vga_plot_d    = 1'b0;
        frame_busy_d  = frame_busy_q;
        timeout_err_d = timeout_err_q;
        overrun_err_d = overrun_err_q | (frame_tick & frame_busy_q);
        release_now   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d      = ST_CLEAR;
                    cx_d         = '0;
                    cy_d         = '0;
                    served_d     = '0;
                    frame_busy_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                vga_x_d      = cx_q;
                vga_y_d      = cy_q;
                vga_colour_d = BG_COLOUR;
                vga_plot_d   = 1'b1;
                if (cx_q == X_W'(CLR_W - 1)) begin
                    cx_d = '0;
                    if (cy_q == Y_W'(CLR_H - 1)) begin
                        state_d = ST_ARB;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            ST_ARB: begin
                if (pick_valid) begin
                    g_d     = pick_g;
                    state_d = ST_START;
                end else begin
                    state_d      = ST_IDLE;
                    frame_busy_d = 1'b0;
                end
            end
            ST_START: begin
                start_d = g_bit;
                grant_d = g_bit;
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The pixel presented alongside done is still forwarded.
                vga_x_d      = x_in[g_q*X_W +: X_W];
                vga_y_d      = y_in[g_q*Y_W +: Y_W];
                vga_colour_d = colour_in[g_q*3 +: 3];
                vga_plot_d   = plot_in[g_q];
                release_now  = done[g_q] | (wd_q == WD_W'(TIMEOUT - 1));
                if (release_now) begin
                    served_d = served_q | g_bit;
                    rr_d     = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                    grant_d  = '0;
                    state_d  = ST_ARB;
                    if (!done[g_q]) begin
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cx_q          <= '0;
            cy_q          <= '0;
            served_q      <= '0;
            rr_q          <= '0;
            g_q           <= '0;
            wd_q          <= '0;
            start_q       <= '0;
            grant_q       <= '0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_colour_q  <= '0;
            vga_plot_q    <= 1'b0;
            frame_busy_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            served_q      <= served_d;
            rr_q          <= rr_d;
            g_q           <= g_d;
            wd_q          <= wd_d;
            start_q       <= start_d;
            grant_q       <= grant_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_colour_q  <= vga_colour_d;
            vga_plot_q    <= vga_plot_d;
            frame_busy_q  <= frame_busy_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign start       = start_q;
    assign grant       = grant_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_colour_q;
    assign vga_plot    = vga_plot_q;
    assign frame_busy  = frame_busy_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter with a 4x2 clear region and a 20-cycle watchdog.
// A frame-level sequential model predicts every output each cycle.
module tb_vga_draw_arbiter;
    import draw_pkg::*;

    localparam int NQ      = 4;
    localparam int CW      = 4;
    localparam int CH      = 2;
    localparam int TMO     = 20;

    logic          clock;
    logic          reset;
    logic          frame_tick;
    logic [3:0]    req;
    logic [3:0]    done;
    logic [31:0]   x_in;
    logic [27:0]   y_in;
    logic [11:0]   colour_in;
    logic [3:0]    plot_in;
    logic [3:0]    start;
    logic [3:0]    grant;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot;
    logic          frame_busy;
    logic          timeout_err;
    logic          overrun_err;
    draw_state_t   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    int dly [NQ];
    int cnt [NQ];
    int start_log [$];
    logic [17:0] exp_q [$];

    logic [3:0] exp_start  = '0;
    logic [3:0] exp_grant  = '0;
    logic       exp_plot   = 1'b0;
    logic [7:0] exp_x      = '0;
    logic [6:0] exp_y      = '0;
    logic [2:0] exp_col    = '0;
    logic       exp_busy   = 1'b0;
    logic       exp_terr   = 1'b0;
    logic       exp_oerr   = 1'b0;
    logic [3:0] m_served   = '0;
    int         m_ptr      = 0;

    vga_draw_arbiter #(
        .NUM_REQ(NQ), .X_W(8), .Y_W(7), .CLR_W(CW), .CLR_H(CH),
        .BG_COLOUR(3'b000), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .req(req), .done(done), .x_in(x_in), .y_in(y_in),
        .colour_in(colour_in), .plot_in(plot_in), .start(start), .grant(grant),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .frame_busy(frame_busy), .timeout_err(timeout_err),
        .overrun_err(overrun_err), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: one clock edge seen by the model; a tick during a busy frame is an overrun.
    task automatic tick_edge();
        @(posedge clock);
        if (frame_tick && exp_busy) exp_oerr = 1'b1;
    endtask

    initial begin : model
        int g;
        int n;
        logic [3:0] pend;
        wait (reset === 1'b1);
        forever begin
            do begin
                tick_edge();
                exp_plot = 1'b0;
            end while (!frame_tick);
            exp_busy = 1'b1;
            m_served = '0;
            for (int yy = 0; yy < CH; yy++) begin
                for (int xx = 0; xx < CW; xx++) begin
                    tick_edge();
                    exp_plot = 1'b1;
                    exp_x    = 8'(xx);
                    exp_y    = 7'(yy);
                    exp_col  = 3'b000;
                end
            end
            forever begin
                tick_edge();
                exp_plot = 1'b0;
                pend = req & ~m_served;
                if (pend == 4'b0000) begin
                    exp_busy = 1'b0;
                    break;
                end
                g = -1;
                for (int k = 0; k < NQ; k++) begin
                    if (g < 0 && pend[(m_ptr + k) % NQ]) g = (m_ptr + k) % NQ;
                end
                tick_edge();
                exp_start = 4'b0001 << g;
                exp_grant = exp_start;
                exp_plot  = 1'b0;
                n = 0;
                forever begin
                    tick_edge();
                    exp_start = '0;
                    n++;
                    exp_x    = x_in[g*8 +: 8];
                    exp_y    = y_in[g*7 +: 7];
                    exp_col  = colour_in[g*3 +: 3];
                    exp_plot = plot_in[g];
                    if (done[g] || n == TMO) begin
                        if (!done[g]) exp_terr = 1'b1;
                        m_served[g] = 1'b1;
                        m_ptr       = (g + 1) % NQ;
                        exp_grant   = '0;
                        break;
                    end
                end
            end
        end
    end

    // Scoreboard compare on the falling edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("start", 32'(start), 32'(exp_start));
            chk("grant", 32'(grant), 32'(exp_grant));
            chk("vga_plot", 32'(vga_plot), 32'(exp_plot));
            chk("frame_busy", 32'(frame_busy), 32'(exp_busy));
            chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
            chk("overrun_err", 32'(overrun_err), 32'(exp_oerr));
            if (exp_plot) begin
                chk("vga_x", 32'(vga_x), 32'(exp_x));
                chk("vga_y", 32'(vga_y), 32'(exp_y));
                chk("vga_colour", 32'(vga_colour), 32'(exp_col));
            end
            for (int i = 0; i < NQ; i++) begin
                if (start[i]) start_log.push_back(i);
            end
        end
    end

    // Renderer responders: done pulses dly[i] cycles after start[i] (0 = never).
    initial begin
        done = '0;
        for (int i = 0; i < NQ; i++) cnt[i] = 0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < NQ; i++) begin
                done[i] = 1'b0;
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) done[i] = 1'b1;
                end
                if (start[i] && dly[i] > 0) cnt[i] = dly[i];
            end
        end
    end

    // Driver tasks
    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (frame_busy && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("frame_end", 32'(frame_busy), 32'd0);
    endtask

    task automatic wait_grant(input int i);
        int n;
        n = 0;
        while (!grant[i] && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("wait_grant", 32'(grant[i]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout t=%0t", $time);
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        int cyc;
        int px_cnt;
        int n;
        reset = 1'b0;
        frame_tick = 1'b0;
        req = '0;
        plot_in = '0;
        x_in = '0;
        y_in = '0;
        colour_in = '0;
        for (int i = 0; i < NQ; i++) dly[i] = 0;
        repeat (3) @(negedge clock);
        chk("rst_plot", 32'(vga_plot), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_errs", 32'({timeout_err, overrun_err}), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        cmp_en = 1'b1;

        // Clear sweep with no requesters.
        exp_q.push_back({8'd0, 7'd0, 3'b000});
        exp_q.push_back({8'd1, 7'd0, 3'b000});
        exp_q.push_back({8'd2, 7'd0, 3'b000});
        exp_q.push_back({8'd3, 7'd0, 3'b000});
        exp_q.push_back({8'd0, 7'd1, 3'b000});
        exp_q.push_back({8'd1, 7'd1, 3'b000});
        exp_q.push_back({8'd2, 7'd1, 3'b000});
        exp_q.push_back({8'd3, 7'd1, 3'b000});
        pulse_tick();
        cyc = 1;
        px_cnt = 0;
        while (frame_busy && cyc < 50) begin
            if (vga_plot) begin
                px_cnt++;
                if (exp_q.size() > 0) chk("clear_px", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
            end
            @(negedge clock);
            cyc++;
        end
        chk("clear_px_count", 32'(px_cnt), 32'd8);
        chk("busy_fall_cycles", 32'(cyc), 32'd10);

        // Round-robin over two frames.
        req = 4'b1011;
        for (int i = 0; i < NQ; i++) dly[i] = 5;
        start_log.delete();
        pulse_tick();
        wait_idle();
        pulse_tick();
        wait_idle();
        chk("rr_log_len", 32'(start_log.size()), 32'd6);
        if (start_log.size() == 6) begin
            chk("rr_0", 32'(start_log[0]), 32'd0);
            chk("rr_1", 32'(start_log[1]), 32'd1);
            chk("rr_2", 32'(start_log[2]), 32'd3);
            chk("rr_3", 32'(start_log[3]), 32'd0);
            chk("rr_4", 32'(start_log[4]), 32'd1);
            chk("rr_5", 32'(start_log[5]), 32'd3);
        end

        // Watchdog release on requester 2, then requester 3 is served.
        req = 4'b1100;
        dly[2] = 0;
        dly[3] = 4;
        pulse_tick();
        wait_grant(2);
        n = 0;
        while (grant[2] && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("timeout_hold", 32'(n), 32'd20);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        wait_grant(3);
        wait_idle();
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // Pass-through from requester 1 with a competing plot on requester 2.
        req = 4'b0110;
        dly[1] = 5;
        dly[2] = 3;
        pulse_tick();
        wait_grant(1);
        x_in[8 +: 8] = 8'd42;
        y_in[7 +: 7] = 7'd17;
        colour_in[3 +: 3] = 3'b101;
        x_in[16 +: 8] = 8'd99;
        y_in[14 +: 7] = 7'd99;
        colour_in[6 +: 3] = 3'b010;
        plot_in = 4'b0110;
        req = 4'b0100;
        @(negedge clock);
        plot_in = 4'b0000;
        chk("pt_x", 32'(vga_x), 32'd42);
        chk("pt_y", 32'(vga_y), 32'd17);
        chk("pt_col", 32'(vga_colour), 32'd5);
        chk("pt_plot", 32'(vga_plot), 32'd1);
        chk("pt_grant_held", 32'(grant), 32'h2);
        wait_idle();

        // Overrun during WAIT, then reset mid-grant.
        req = 4'b0001;
        dly[0] = 0;
        pulse_tick();
        wait_grant(0);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        chk("ovr_err", 32'(overrun_err), 32'd1);
        chk("ovr_grant", 32'(grant), 32'h1);
        chk("ovr_busy", 32'(frame_busy), 32'd1);
        cmp_en = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("rst2_grant", 32'(grant), 32'd0);
        chk("rst2_plot", 32'(vga_plot), 32'd0);
        chk("rst2_errs", 32'({timeout_err, overrun_err}), 32'd0);
        chk("rst2_busy", 32'(frame_busy), 32'd0);
        chk("rst2_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Per-frame scheduler that owns the single VGA pixel-write port (x, y, colour, writeEn).
- On each frame tick it clears the playfield to the background colour. It then grants the port to each requesting renderer (score, alien, player, bullet) in round-robin order.
- Each granted renderer receives a one-cycle start pulse. It returns done when its sprite is fully drawn.
- Sits between the renderers and the VGA adapter and replaces ad-hoc OR-ing of plot signals.

Parameters:
- NUM_REQ, 4, number of renderer requesters (index 0 = score).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- CLR_W, 160, clear-region width in pixels.
- CLR_H, 120, clear-region height in pixels.
- BG_COLOUR, 3'b000, colour written during clear.
- TIMEOUT, 4095, maximum cycles a grant may be held before forced release.

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-low
- frame_tick  in  1  one-cycle pulse at frame start (rate divider)
- req  in  NUM_REQ  renderer wants a slot this frame; level, sampled in ARB
- done  in  NUM_REQ  renderer finished; sampled only for the granted index in WAIT
- x_in  in  NUM_REQ*X_W  packed renderer x, slice i = requester i
- y_in  in  NUM_REQ*Y_W  packed renderer y
- colour_in  in  NUM_REQ*3  packed renderer colour
- plot_in  in  NUM_REQ  renderer writeEn
- start  out  NUM_REQ  one-hot, one-cycle pulse to begin drawing
- grant  out  NUM_REQ  one-hot, held for the whole ownership
- vga_x  out  X_W  to VGA x
- vga_y  out  Y_W  to VGA y
- vga_colour  out  3  to VGA colour
- vga_plot  out  1  to VGA writeEn
- frame_busy  out  1  high from frame accept until the last grant ends
- timeout_err  out  1  sticky; set on forced release, cleared only by reset
- overrun_err  out  1  sticky; set when frame_tick arrives while frame_busy

Behaviour:

Reset (reset==0 at a clock edge):
- State goes to IDLE; every output goes to 0; rr pointer = 0; served mask = 0; counters = 0.
- Reset mid-CLEAR or mid-WAIT aborts immediately. The next cycle shows vga_plot=0 and grant=0.

All outputs are registered. vga_* carry one cycle of latency from the source selected in the previous cycle.

IDLE:
- vga_plot=0.
- frame_tick -> CLEAR; set cx=cy=0, served=0, frame_busy=1.

CLEAR:
- Each cycle drives vga_x=cx, vga_y=cy, vga_colour=BG_COLOUR, vga_plot=1.
- cx increments and wraps at CLR_W-1, at which point cy increments.
- After pixel (CLR_W-1, CLR_H-1) -> ARB. Exactly CLR_W*CLR_H plot cycles.

ARB (1 cycle, vga_plot=0):
- pend = req & ~served.
- pend==0 -> IDLE and frame_busy=0.
- Otherwise choose the first set bit of pend searching from the rr pointer upward, wrapping; its index is g -> START.

START (1 cycle):
- start[g]=1 and grant[g]=1 -> WAIT; watchdog=0.

WAIT:
- grant[g] held.
- Every cycle the registers capture x_in[g], y_in[g], colour_in[g], plot_in[g]. This includes the cycle done[g] is seen, so a final pixel asserted with done is still written.
- done[g]==1 -> served[g]=1, rr pointer=(g+1) mod NUM_REQ, grant drops next cycle -> ARB.
- watchdog reaching TIMEOUT without done -> same release path, and timeout_err=1.

General rules:
- done or plot from a non-granted requester is ignored.
- req deasserting during WAIT does not end the grant; only done or timeout does.
- Each requester is served at most once per frame. A req raised after its turn in the same frame waits for the next frame.
- frame_tick while frame_busy is ignored and sets overrun_err=1. The current frame continues unchanged.
- frame_tick and done in the same cycle: done is handled normally, and overrun_err is set.

Decomposition:
- Shared package draw_pkg holds:
  - state encoding (IDLE, CLEAR, ARB, START, WAIT)
  - coordinate widths
  - BG_COLOUR default
  - requester index constants (REQ_SCORE=0, REQ_ALIEN=1, REQ_PLAYER=2, REQ_BULLET=3)
- One sub-module, rr_pick: combinational round-robin first-one finder taking pend and the pointer, returning g and a valid flag.

Test Plan:
- Bench uses CLR_W=4, CLR_H=2.
- Clear sweep: after reset, pulse frame_tick with req=0 -> 8 plot cycles at (0,0),(1,0)..(3,0),(0,1)..(3,1), colour 000. Then ARB -> IDLE, frame_busy falls 10 cycles after the tick.
- Round-robin: req=4'b1011, each renderer raises done 5 cycles after its start -> start pulses order 0,1,3. Next frame with pointer=0 gives the same order 0,1,3.
- Pass-through: granted requester 1 drives x=8'd42, y=7'd17, colour=3'b101, plot=1 for one cycle -> next cycle vga=(42,17,101,1). A simultaneous plot on requester 2 never appears.
- Timeout: TIMEOUT=20, requester 2 never asserts done -> grant[2] drops after 20 WAIT cycles, timeout_err=1 and stays 1. Requester 3 is then started.
- Overrun/reset: frame_tick during WAIT -> overrun_err=1 and grant is unchanged. Reset low mid-WAIT -> next cycle grant=0, vga_plot=0, both errors cleared.
